// File: rtl/stage4ma.sv
// Memory-access stage: forwards ALU ops in one cycle, runs a req/ack
// data-memory handshake for loads/stores with a timeout abort.
//
// Ports:
//   clk, rst (async, active-low)
//   enable_in, pc_in, instr_in, tgt_gp_in, tgt_sr_in, result_in,
//     flags_in, store_data_in, branch_taken_in : from execute
//   stall_out                                  : hold upstream
//   mem_req, mem_we, mem_addr, mem_wdata       : to data memory
//   mem_ack, mem_rdata                         : from data memory
//   enable_out, pc_out, instr_out, tgt_gp_out, tgt_sr_out,
//     result_out, flags_out, branch_taken_out  : to write-back
//   mem_err_out                                : sticky timeout flag
module stage4ma #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [23:0] pc_in,
  input  logic [23:0] instr_in,
  input  logic [3:0]  tgt_gp_in,
  input  logic [3:0]  tgt_sr_in,
  input  logic [23:0] result_in,
  input  logic [3:0]  flags_in,
  input  logic [23:0] store_data_in,
  input  logic        branch_taken_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [23:0] mem_rdata,
  output logic        enable_out,
  output logic [23:0] pc_out,
  output logic [23:0] instr_out,
  output logic [3:0]  tgt_gp_out,
  output logic [3:0]  tgt_sr_out,
  output logic [23:0] result_out,
  output logic [3:0]  flags_out,
  output logic        branch_taken_out,
  output logic        mem_err_out
);

  localparam logic [7:0] OPC_R_LD  = 8'h20;
  localparam logic [7:0] OPC_R_ST  = 8'h21;
  localparam logic [7:0] OPC_I_LDi = 8'h60;
  localparam logic [7:0] OPC_I_STi = 8'h61;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] wdata_q, wdata_d;

  // sideband held while the access is outstanding
  logic [23:0] cpc_q, cpc_d;
  logic [23:0] cins_q, cins_d;
  logic [3:0]  cgp_q, cgp_d;
  logic [3:0]  csr_q, csr_d;
  logic [3:0]  cfl_q, cfl_d;
  logic        cbr_q, cbr_d;

  logic        en_q, en_d;
  logic [23:0] pc_q, pc_d;
  logic [23:0] ins_q, ins_d;
  logic [3:0]  gp_q, gp_d;
  logic [3:0]  sr_q, sr_d;
  logic [23:0] res_q, res_d;
  logic [3:0]  fl_q, fl_d;
  logic        br_q, br_d;
  logic        err_q, err_d;

  logic [7:0]  opc;
  logic        is_rd;
  logic        is_wr;
  logic [3:0]  rd_flags;

  assign opc   = instr_in[23:16];
  assign is_rd = (opc == OPC_R_LD) || (opc == OPC_I_LDi);
  assign is_wr = (opc == OPC_R_ST) || (opc == OPC_I_STi);

  always_comb begin
    rd_flags         = '0;
    rd_flags[FLAG_Z] = (mem_rdata == 24'd0);
    rd_flags[FLAG_N] = mem_rdata[23];
    rd_flags[FLAG_C] = 1'b0;
    rd_flags[FLAG_V] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cpc_d   = cpc_q;
    cins_d  = cins_q;
    cgp_d   = cgp_q;
    csr_d   = csr_q;
    cfl_d   = cfl_q;
    cbr_d   = cbr_q;
    en_d    = 1'b0;
    pc_d    = pc_q;
    ins_d   = ins_q;
    gp_d    = gp_q;
    sr_d    = sr_q;
    res_d   = res_q;
    fl_d    = fl_q;
    br_d    = br_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          if (is_rd || is_wr) begin
            cpc_d   = pc_in;
            cins_d  = instr_in;
            cgp_d   = tgt_gp_in;
            csr_d   = tgt_sr_in;
            cfl_d   = flags_in;
            cbr_d   = branch_taken_in;
            addr_d  = result_in;
            we_d    = is_wr;
            wdata_d = is_wr ? store_data_in : 24'd0;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            en_d  = 1'b1;
            pc_d  = pc_in;
            ins_d = instr_in;
            gp_d  = tgt_gp_in;
            sr_d  = tgt_sr_in;
            res_d = result_in;
            fl_d  = flags_in;
            br_d  = branch_taken_in;
          end
        end
      end
      ACCESS: begin
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          state_d = IDLE;
          en_d    = 1'b1;
          pc_d    = cpc_q;
          ins_d   = cins_q;
          gp_d    = cgp_q;
          sr_d    = csr_q;
          br_d    = cbr_q;
          if (!mem_ack) begin
            err_d = 1'b1;
            res_d = 24'd0;
            fl_d  = cfl_q;
          end else if (we_q) begin
            res_d = addr_q;
            fl_d  = cfl_q;
          end else begin
            res_d = mem_rdata;
            fl_d  = rd_flags;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cpc_q   <= '0;
      cins_q  <= '0;
      cgp_q   <= '0;
      csr_q   <= '0;
      cfl_q   <= '0;
      cbr_q   <= 1'b0;
      en_q    <= 1'b0;
      pc_q    <= '0;
      ins_q   <= '0;
      gp_q    <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      fl_q    <= '0;
      br_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cpc_q   <= cpc_d;
      cins_q  <= cins_d;
      cgp_q   <= cgp_d;
      csr_q   <= csr_d;
      cfl_q   <= cfl_d;
      cbr_q   <= cbr_d;
      en_q    <= en_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      gp_q    <= gp_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      fl_q    <= fl_d;
      br_q    <= br_d;
      err_q   <= err_d;
    end
  end

  assign stall_out        = (state_q == ACCESS);
  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign enable_out       = en_q;
  assign pc_out           = pc_q;
  assign instr_out        = ins_q;
  assign tgt_gp_out       = gp_q;
  assign tgt_sr_out       = sr_q;
  assign result_out       = res_q;
  assign flags_out        = fl_q;
  assign branch_taken_out = br_q;
  assign mem_err_out      = err_q;

endmodule

// File: tb/tb_stage4ma.sv
// Directed bench for stage4ma: vector table of single instructions
// plus reset, idle-ack, back-to-back and mid-access reset sequences.
module tb_stage4ma;

  localparam logic [7:0] LD  = 8'h20;
  localparam logic [7:0] ST  = 8'h21;
  localparam logic [7:0] LDI = 8'h60;
  localparam logic [7:0] STI = 8'h61;
  localparam logic [7:0] ADD = 8'h01;
  localparam logic [7:0] SUB = 8'h02;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_in = 1'b0;
  logic [23:0] pc_in = '0;
  logic [23:0] instr_in = '0;
  logic [3:0]  tgt_gp_in = '0;
  logic [3:0]  tgt_sr_in = '0;
  logic [23:0] result_in = '0;
  logic [3:0]  flags_in = '0;
  logic [23:0] store_data_in = '0;
  logic        branch_taken_in = 1'b0;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_rdata = '0;
  logic        enable_out;
  logic [23:0] pc_out;
  logic [23:0] instr_out;
  logic [3:0]  tgt_gp_out;
  logic [3:0]  tgt_sr_out;
  logic [23:0] result_out;
  logic [3:0]  flags_out;
  logic        branch_taken_out;
  logic        mem_err_out;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  stage4ma #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
    .tgt_gp_in(tgt_gp_in), .tgt_sr_in(tgt_sr_in),
    .result_in(result_in), .flags_in(flags_in),
    .store_data_in(store_data_in),
    .branch_taken_in(branch_taken_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .enable_out(enable_out), .pc_out(pc_out),
    .instr_out(instr_out), .tgt_gp_out(tgt_gp_out),
    .tgt_sr_out(tgt_sr_out), .result_out(result_out),
    .flags_out(flags_out),
    .branch_taken_out(branch_taken_out),
    .mem_err_out(mem_err_out)
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] res;
    logic [3:0]  fl;
    logic [23:0] sd;
    int          d;
    logic [23:0] rd;
    logic [23:0] eres;
    logic [3:0]  efl;
    int          estall;
    logic        eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    pc_in         = 24'($urandom);
    instr_in      = 24'($urandom);
    tgt_gp_in     = 4'($urandom);
    tgt_sr_in     = 4'($urandom);
    result_in     = 24'($urandom);
    flags_in      = 4'($urandom);
    store_data_in = 24'($urandom);
    branch_taken_in = 1'($urandom);
    mem_rdata     = 24'($urandom);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " req"}, {31'd0, mem_req}, 0);
    chk({nm, " stall"}, {31'd0, stall_out}, 0);
    chk({nm, " en"}, {31'd0, enable_out}, 0);
    chk({nm, " err"}, {31'd0, mem_err_out}, 0);
    chk({nm, " res"}, {8'd0, result_out}, 0);
    chk({nm, " misc"},
        {pc_out[7:0], instr_out[7:0], tgt_gp_out, tgt_sr_out,
         flags_out, mem_we, branch_taken_out, 2'b00}, 0);
    chk({nm, " bus"}, {mem_addr[15:0], mem_wdata[15:0]}, 0);
  endtask

  vec_t v[9];

  initial begin
    v[0] = '{ADD, 24'h000123, 4'h0, 24'h0, 0, 24'h0,
             24'h000123, 4'h0, 0, 1'b0};
    v[1] = '{LD, 24'h000040, 4'h0, 24'h0, 3, 24'h800000,
             24'h800000, 4'b0100, 4, 1'b0};
    v[2] = '{ST, 24'h000010, 4'hA, 24'hABCDEF, 1, 24'h0,
             24'h000010, 4'hA, 2, 1'b0};
    v[3] = '{LDI, 24'h000055, 4'hF, 24'h0, 0, 24'h000000,
             24'h000000, 4'b0001, 1, 1'b0};
    v[4] = '{STI, 24'h000020, 4'h3, 24'h123456, 2, 24'h0,
             24'h000020, 4'h3, 3, 1'b0};
    v[5] = '{SUB, 24'hFFFFFF, 4'h5, 24'h0, 0, 24'h0,
             24'hFFFFFF, 4'h5, 0, 1'b0};
    v[6] = '{LD, 24'h000077, 4'h6, 24'h0, 99, 24'h0,
             24'h000000, 4'h6, 4, 1'b1};
    v[7] = '{ADD, 24'h000042, 4'h2, 24'h0, 0, 24'h0,
             24'h000042, 4'h2, 0, 1'b1};
    v[8] = '{LD, 24'h000033, 4'h9, 24'h0, 0, 24'h00ABCD,
             24'h00ABCD, 4'b0000, 1, 1'b1};

    // reset held with random inputs
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      garbage();
      enable_in = 1'b1;
      mem_ack   = 1'($urandom);
      step();
    end
    chk_zero("reset");
    enable_in = 1'b0;
    mem_ack   = 1'b0;
    rst       = 1'b1;
    step();

    // ack in IDLE is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle ack en", {31'd0, enable_out}, 0);
    chk("idle ack req", {31'd0, mem_req}, 0);

    for (int i = 0; i < 9; i++) begin
      bit mem_op;
      bit wr;
      int stalls;
      int reqs;
      int addr_bad;
      int cyc;
      string p;
      p      = $sformatf("v%0d", i);
      mem_op = (v[i].op == LD) || (v[i].op == LDI) ||
               (v[i].op == ST) || (v[i].op == STI);
      wr     = (v[i].op == ST) || (v[i].op == STI);
      enable_in       = 1'b1;
      pc_in           = 24'h000100 + 24'(i);
      instr_in        = {v[i].op, 16'h1234 + 16'(i)};
      tgt_gp_in       = 4'(i);
      tgt_sr_in       = ~4'(i);
      branch_taken_in = 1'(i);
      result_in       = v[i].res;
      flags_in        = v[i].fl;
      store_data_in   = v[i].sd;
      mem_ack         = 1'b0;
      step();
      enable_in = 1'b0;
      garbage();
      if (mem_op) begin
        chk({p, " addr"}, {8'd0, mem_addr}, {8'd0, v[i].res});
        chk({p, " we"}, {31'd0, mem_we}, {31'd0, wr});
        chk({p, " wdata"}, {8'd0, mem_wdata},
            {8'd0, wr ? v[i].sd : 24'd0});
      end
      stalls = 0;
      reqs = 0;
      addr_bad = 0;
      cyc = 0;
      while (!enable_out && cyc < 20) begin
        if (stall_out) stalls++;
        if (mem_req) reqs++;
        if (mem_addr !== v[i].res) addr_bad++;
        mem_ack   = (cyc == v[i].d);
        mem_rdata = (cyc == v[i].d) ? v[i].rd : 24'($urandom);
        step();
        mem_ack = 1'b0;
        cyc++;
      end
      chk({p, " done"}, {31'd0, enable_out}, 1);
      chk({p, " stalls"}, stalls, v[i].estall);
      chk({p, " reqs"}, reqs, v[i].estall);
      if (mem_op) chk({p, " addr held"}, addr_bad, 0);
      chk({p, " result"}, {8'd0, result_out}, {8'd0, v[i].eres});
      chk({p, " flags"}, {28'd0, flags_out}, {28'd0, v[i].efl});
      chk({p, " pc"}, {8'd0, pc_out}, 32'h100 + i);
      chk({p, " instr"}, {8'd0, instr_out},
          {8'd0, v[i].op, 16'h1234 + 16'(i)});
      chk({p, " tgt"}, {24'd0, tgt_gp_out, tgt_sr_out},
          {24'd0, 4'(i), ~4'(i)});
      chk({p, " br"}, {31'd0, branch_taken_out}, {31'd0, 1'(i)});
      chk({p, " err"}, {31'd0, mem_err_out}, {31'd0, v[i].eerr});
      chk({p, " req low"}, {31'd0, mem_req}, 0);
      chk({p, " stall low"}, {31'd0, stall_out}, 0);
      step();
      chk({p, " pulse"}, {31'd0, enable_out}, 0);
      chk({p, " hold"}, {8'd0, result_out}, {8'd0, v[i].eres});
    end

    // back-to-back loads with immediate acks
    enable_in = 1'b1;
    pc_in     = 24'h000A00;
    instr_in  = {LD, 16'h0001};
    result_in = 24'h000100;
    step();
    chk("b2b req1", {31'd0, mem_req}, 1);
    chk("b2b addr1", {8'd0, mem_addr}, 32'h100);
    pc_in     = 24'h000B00;
    instr_in  = {LDI, 16'h0002};
    result_in = 24'h000200;
    mem_ack   = 1'b1;
    mem_rdata = 24'h111111;
    chk("b2b stall ack cyc", {31'd0, stall_out}, 1);
    step();
    mem_ack = 1'b0;
    chk("b2b en1", {31'd0, enable_out}, 1);
    chk("b2b res1", {8'd0, result_out}, 32'h111111);
    chk("b2b pc1", {8'd0, pc_out}, 32'hA00);
    chk("b2b gap", {31'd0, mem_req}, 0);
    chk("b2b gap stall", {31'd0, stall_out}, 0);
    step();
    enable_in = 1'b0;
    chk("b2b req2", {31'd0, mem_req}, 1);
    chk("b2b addr2", {8'd0, mem_addr}, 32'h200);
    chk("b2b en gap", {31'd0, enable_out}, 0);
    mem_ack   = 1'b1;
    mem_rdata = 24'h222222;
    step();
    mem_ack = 1'b0;
    chk("b2b en2", {31'd0, enable_out}, 1);
    chk("b2b res2", {8'd0, result_out}, 32'h222222);
    chk("b2b pc2", {8'd0, pc_out}, 32'hB00);
    step();
    chk("b2b en2 pulse", {31'd0, enable_out}, 0);

    // reset in the middle of an access
    enable_in = 1'b1;
    instr_in  = {ST, 16'h0003};
    result_in = 24'h000300;
    step();
    enable_in = 1'b0;
    chk("mid req", {31'd0, mem_req}, 1);
    #2 rst = 1'b0;
    #1;
    chk_zero("mid reset");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post reset req", {31'd0, mem_req}, 0);
    chk("post reset stall", {31'd0, stall_out}, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
